// File: rtl/alu_pkg.sv
// Shared constants, opcode map and FSM encoding for the ALU issue/writeback stage.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_W-1:0] OP_NAND = 3'd2;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
    localparam logic [OP_W-1:0] OP_ADD  = 3'd4;
    localparam logic [OP_W-1:0] OP_SUB  = 3'd5;
    localparam logic [OP_W-1:0] OP_MUL  = 3'd6;
    localparam logic [OP_W-1:0] OP_ILL  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    function automatic logic is_illegal(input logic [OP_W-1:0] op);
        return op == OP_ILL;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port, async clear.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    output logic [DW-1:0] rdata1,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata2
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] regs [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback stage around the external combinational ALU: command latch,
// operand/opcode registers, register file writeback and a held response channel.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int ADDR_W_P = ADDR_W,
    parameter int OP_W_P   = OP_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_ld,
    input  logic [OP_W_P-1:0]   cmd_op,
    input  logic [ADDR_W_P-1:0] cmd_rs1,
    input  logic [ADDR_W_P-1:0] cmd_rs2,
    input  logic [ADDR_W_P-1:0] cmd_rd,
    input  logic [DATA_W_P-1:0] cmd_imm,
    output logic [DATA_W_P-1:0] alu_a,
    output logic [DATA_W_P-1:0] alu_b,
    output logic [OP_W_P-1:0]   alu_f,
    input  logic [DATA_W_P-1:0] alu_y,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W_P-1:0] rsp_data,
    output logic [ADDR_W_P-1:0] rsp_rd,
    output logic                rsp_err,
    output state_e              fsm_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
    // A producer holding valid keeps its payload stable until that edge; cmd_ready is
    // high only in IDLE and rsp_valid only in RESP, so the two channels never overlap.

    state_e              state;
    logic [OP_W_P-1:0]   op_q;
    logic [ADDR_W_P-1:0] rs1_q;
    logic [ADDR_W_P-1:0] rs2_q;
    logic [ADDR_W_P-1:0] rd_q;

    logic                accept;
    logic                rf_we;
    logic [ADDR_W_P-1:0] rf_waddr;
    logic [DATA_W_P-1:0] rf_wdata;
    logic [DATA_W_P-1:0] rf_rdata1;
    logic [DATA_W_P-1:0] rf_rdata2;

    assign accept    = (state == ST_IDLE) && cmd_valid && cmd_ready;
    assign fsm_state = state;

    // Loads write on the accept edge straight from the command bus; ALU results write in EXEC.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = rd_q;
        rf_wdata = alu_y;
        if (accept && cmd_ld) begin
            rf_we    = 1'b1;
            rf_waddr = cmd_rd;
            rf_wdata = cmd_imm;
        end else if (state == ST_EXEC && !is_illegal(op_q)) begin
            rf_we    = 1'b1;
        end
    end

    alu_regfile #(
        .DW (DATA_W_P),
        .AW (ADDR_W_P)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (rf_we),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata),
        .raddr1 (rs1_q),
        .rdata1 (rf_rdata1),
        .raddr2 (rs2_q),
        .rdata2 (rf_rdata2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b0;
            op_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_f     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_rd    <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        op_q      <= cmd_op;
                        rs1_q     <= cmd_rs1;
                        rs2_q     <= cmd_rs2;
                        rd_q      <= cmd_rd;
                        if (cmd_ld) begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= cmd_imm;
                            rsp_rd    <= cmd_rd;
                            rsp_err   <= 1'b0;
                            state     <= ST_RESP;
                        end else begin
                            state     <= ST_READ;
                        end
                    end else begin
                        // First IDLE cycle after reset release raises ready here.
                        cmd_ready <= 1'b1;
                    end
                end
                ST_READ: begin
                    alu_a <= rf_rdata1;
                    alu_b <= rf_rdata2;
                    alu_f <= op_q;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    rsp_valid <= 1'b1;
                    rsp_rd    <= rd_q;
                    if (is_illegal(op_q)) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end else begin
                        rsp_data <= alu_y;
                        rsp_err  <= 1'b0;
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
